// File: rtl/icmp_tx_arbiter_if.sv
// Bundle between the ICMP transmit arbiter, its two clients and the icmp engine.
// The arbiter takes the slave view; the application/engine side takes the master view.
interface icmp_tx_arbiter_if;
    logic        c0_req,      c1_req;
    logic [15:0] c0_byte_num, c1_byte_num;
    logic [47:0] c0_des_mac,  c1_des_mac;
    logic [31:0] c0_des_ip,   c1_des_ip;
    logic [31:0] c0_data,     c1_data;
    logic        c0_grant,    c1_grant;
    logic        c0_tx_req,   c1_tx_req;
    logic        c0_done,     c1_done;
    logic        c0_err,      c1_err;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic [31:0] tx_data;
    logic        tx_req;
    logic        tx_done;

    modport slave (
        input  c0_req, c1_req, c0_byte_num, c1_byte_num, c0_des_mac, c1_des_mac,
               c0_des_ip, c1_des_ip, c0_data, c1_data, tx_req, tx_done,
        output c0_grant, c1_grant, c0_tx_req, c1_tx_req, c0_done, c1_done,
               c0_err, c1_err, tx_start_en, tx_byte_num, des_mac, des_ip, tx_data
    );

    modport master (
        output c0_req, c1_req, c0_byte_num, c1_byte_num, c0_des_mac, c1_des_mac,
               c0_des_ip, c1_des_ip, c0_data, c1_data, tx_req, tx_done,
        input  c0_grant, c1_grant, c0_tx_req, c1_tx_req, c0_done, c1_done,
               c0_err, c1_err, tx_start_en, tx_byte_num, des_mac, des_ip, tx_data
    );
endinterface

// File: rtl/icmp_tx_arbiter.sv
// Round-robin sharing of the icmp engine transmit-command port between two clients,
// with an enforced inter-command gap and a BUSY-state watchdog.
module icmp_tx_arbiter #(
    parameter int GAP_CYCLES = 12,
    parameter int TIMEOUT    = 16384
) (
    input  logic               gmii_tx_clk,
    input  logic               rst_n,
    icmp_tx_arbiter_if.slave   bus
);

    localparam int          GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam logic [15:0] GAP_LAST = 16'(GAP_EFF);
    // Abort is decided in the BUSY cycle whose incremented count hits TIMEOUT-1,
    // so the done/err pulse lands TIMEOUT cycles after START.
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  done_q,  done_d;
    logic [1:0]  err_q,   err_d;
    logic        last_q,  last_d;
    logic [15:0] byte_q,  byte_d;
    logic [47:0] mac_q,   mac_d;
    logic [31:0] ip_q,    ip_d;
    logic [15:0] wd_q,    wd_d;
    logic [15:0] gap_q,   gap_d;

    logic [1:0]  req;
    logic [15:0] req_bytes [2];
    logic [47:0] req_mac   [2];
    logic [31:0] req_ip    [2];
    logic        win;
    logic        busy;

    assign req          = {bus.c1_req, bus.c0_req};
    assign req_bytes[0] = bus.c0_byte_num;
    assign req_bytes[1] = bus.c1_byte_num;
    assign req_mac[0]   = bus.c0_des_mac;
    assign req_mac[1]   = bus.c1_des_mac;
    assign req_ip[0]    = bus.c0_des_ip;
    assign req_ip[1]    = bus.c1_des_ip;

    // On a tie the client that was not served last wins.
    assign win  = (req[0] & req[1]) ? ~last_q : req[1];
    assign busy = (state_q == S_BUSY);

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            last_q  <= 1'b1;
            byte_q  <= 16'd0;
            mac_q   <= 48'd0;
            ip_q    <= 32'd0;
            wd_q    <= 16'd0;
            gap_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            mac_q   <= mac_d;
            ip_q    <= ip_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        last_d  = last_q;
        byte_d  = byte_q;
        mac_d   = mac_q;
        ip_d    = ip_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    if (req_bytes[win] == 16'd0) begin
                        done_d[win] = 1'b1;
                        err_d[win]  = 1'b1;
                        last_d      = win;
                        gap_d       = 16'd0;
                        state_d     = S_GAP;
                    end else begin
                        grant_d = win ? 2'b10 : 2'b01;
                        byte_d  = req_bytes[win];
                        mac_d   = req_mac[win];
                        ip_d    = req_ip[win];
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                wd_d    = 16'd0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                wd_d = wd_q + 16'd1;
                if (bus.tx_done || (wd_q == WD_LAST)) begin
                    done_d  = grant_q;
                    err_d   = bus.tx_done ? 2'b00 : grant_q;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                    gap_d   = 16'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.c0_grant    = grant_q[0];
    assign bus.c1_grant    = grant_q[1];
    assign bus.c0_done     = done_q[0];
    assign bus.c1_done     = done_q[1];
    assign bus.c0_err      = err_q[0];
    assign bus.c1_err      = err_q[1];
    assign bus.c0_tx_req   = bus.tx_req & grant_q[0] & busy;
    assign bus.c1_tx_req   = bus.tx_req & grant_q[1] & busy;
    assign bus.tx_start_en = (state_q == S_START);
    assign bus.tx_byte_num = byte_q;
    assign bus.des_mac     = mac_q;
    assign bus.des_ip      = ip_q;
    assign bus.tx_data     = grant_q[0] ? bus.c0_data :
                             (grant_q[1] ? bus.c1_data : 32'd0);

endmodule
